// File: rtl/morse_pkg.sv
// morse_pkg: FSM state encoding, character codes and the Morse lookup table.
// Digit codes are part of the alphabet only when MORSE_DIGITS_EN is defined.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MARK     = 3'd2,
    GAP      = 3'd3,
    CHAR_GAP = 3'd4,
    WORD_GAP = 3'd5
  } morse_state_e;

  localparam logic [5:0] CODE_SPACE  = 6'd63;
  localparam logic [5:0] CODE_DIGIT0 = 6'd26;
  localparam int         LUT_LEN     = 5;

  // pattern bit 1 = dash, played MSB-first starting at bit len-1
  typedef struct packed {
    logic               ok;
    logic [LUT_LEN-1:0] pattern;
    logic [2:0]         len;
  } morse_sym_t;

  function automatic morse_sym_t mk_sym(input logic [LUT_LEN-1:0] pattern,
                                        input logic [2:0] len);
    morse_sym_t s;
    s.ok      = 1'b1;
    s.pattern = pattern;
    s.len     = len;
    return s;
  endfunction

  function automatic morse_sym_t morse_lookup(input logic [5:0] code);
    morse_sym_t s;
    s = '0;
    case (code)
      6'd0 : s = mk_sym(5'b00001, 3'd2);  // A .-
      6'd1 : s = mk_sym(5'b01000, 3'd4);
      6'd2 : s = mk_sym(5'b01010, 3'd4);
      6'd3 : s = mk_sym(5'b00100, 3'd3);
      6'd4 : s = mk_sym(5'b00000, 3'd1);
      6'd5 : s = mk_sym(5'b00010, 3'd4);
      6'd6 : s = mk_sym(5'b00110, 3'd3);
      6'd7 : s = mk_sym(5'b00000, 3'd4);
      6'd8 : s = mk_sym(5'b00000, 3'd2);
      6'd9 : s = mk_sym(5'b00111, 3'd4);
      6'd10: s = mk_sym(5'b00101, 3'd3);
      6'd11: s = mk_sym(5'b00100, 3'd4);
      6'd12: s = mk_sym(5'b00011, 3'd2);
      6'd13: s = mk_sym(5'b00010, 3'd2);
      6'd14: s = mk_sym(5'b00111, 3'd3);
      6'd15: s = mk_sym(5'b00110, 3'd4);
      6'd16: s = mk_sym(5'b01101, 3'd4);
      6'd17: s = mk_sym(5'b00010, 3'd3);
      6'd18: s = mk_sym(5'b00000, 3'd3);
      6'd19: s = mk_sym(5'b00001, 3'd1);
      6'd20: s = mk_sym(5'b00001, 3'd3);
      6'd21: s = mk_sym(5'b00001, 3'd4);
      6'd22: s = mk_sym(5'b00011, 3'd3);
      6'd23: s = mk_sym(5'b01001, 3'd4);
      6'd24: s = mk_sym(5'b01011, 3'd4);
      6'd25: s = mk_sym(5'b01100, 3'd4);
`ifdef MORSE_DIGITS_EN
      CODE_DIGIT0 + 6'd0: s = mk_sym(5'b11111, 3'd5);
      CODE_DIGIT0 + 6'd1: s = mk_sym(5'b01111, 3'd5);
      CODE_DIGIT0 + 6'd2: s = mk_sym(5'b00111, 3'd5);
      CODE_DIGIT0 + 6'd3: s = mk_sym(5'b00011, 3'd5);
      CODE_DIGIT0 + 6'd4: s = mk_sym(5'b00001, 3'd5);
      CODE_DIGIT0 + 6'd5: s = mk_sym(5'b00000, 3'd5);
      CODE_DIGIT0 + 6'd6: s = mk_sym(5'b10000, 3'd5);
      CODE_DIGIT0 + 6'd7: s = mk_sym(5'b11000, 3'd5);
      CODE_DIGIT0 + 6'd8: s = mk_sym(5'b11100, 3'd5);
      CODE_DIGIT0 + 6'd9: s = mk_sym(5'b11110, 3'd5);
`endif
      CODE_SPACE: s = mk_sym('0, 3'd0);
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic code_ok(input logic [5:0] code);
    morse_sym_t s;
    s = morse_lookup(code);
    return s.ok;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// morse_fifo: small character FIFO with a registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module morse_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/morse_tx.sv
// morse_tx: buffered Morse keyer, dot = 1 unit, dash = 3, element gap 1, char gap 3, word gap 7.
// Define MORSE_DIGITS_EN to accept digit codes 26-35 (needs MAX_LEN >= 5).
//   state    | meaning
//   IDLE     | wait for a queued character, pop it
//   LOAD     | latch pattern/len from the lookup
//   MARK     | key on for 1 (dot) or 3 (dash) units
//   GAP      | key off 1 unit between elements
//   CHAR_GAP | key off 3 units after a character
//   WORD_GAP | key off 4 more units for a space
import morse_pkg::*;

module morse_tx #(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int DEPTH       = 4,
  parameter int MAX_LEN     = 5
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [5:0] char_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       key_o,
  output logic       dot_o,
  output logic       dash_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  localparam int TW    = $clog2(UNIT_CYCLES);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  morse_state_e       state_q;
  logic [5:0]         code_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TW-1:0]      tmr_q;
  logic [1:0]         unit_q;
  logic               key_q, dot_q, dash_q, err_q;

  logic               fifo_full, fifo_empty, push, pop;
  logic [5:0]         fifo_dout;
  logic               in_ok, tick, cur_bit, done;
  logic [1:0]         need_m1;
  morse_sym_t         ld;

  assign in_ok   = code_ok(char_i);
  assign ready_o = !fifo_full;
  assign push    = valid_i && ready_o && in_ok;
  assign pop     = (state_q == IDLE) && !fifo_empty;
  assign ld      = morse_lookup(code_q);
  assign cur_bit = pattern_q[idx_q];
  assign tick    = (tmr_q == TW'(UNIT_CYCLES - 1));
  assign done    = tick && (unit_q == need_m1);

  always_comb begin
    need_m1 = 2'd0;
    case (state_q)
      MARK:     need_m1 = cur_bit ? 2'd2 : 2'd0;
      CHAR_GAP: need_m1 = 2'd2;
      WORD_GAP: need_m1 = 2'd3;
      default:  need_m1 = 2'd0;
    endcase
  end

  morse_fifo #(.DEPTH(DEPTH), .WIDTH(6)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (char_i),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pattern_q <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      unit_q    <= '0;
      key_q     <= 1'b0;
      dot_q     <= 1'b0;
      dash_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= valid_i && ready_o && !in_ok;
      // key outputs follow the state one cycle later, so mark lengths stay exact
      key_q  <= (state_q == MARK);
      dot_q  <= (state_q == MARK) && !cur_bit;
      dash_q <= (state_q == MARK) && cur_bit;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            code_q  <= fifo_dout;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          pattern_q <= ld.pattern[MAX_LEN-1:0];
          idx_q     <= IDX_W'(ld.len - 3'd1);
          tmr_q     <= '0;
          unit_q    <= '0;
          state_q   <= (code_q == CODE_SPACE || !ld.ok) ? WORD_GAP : MARK;
        end
        MARK, GAP, CHAR_GAP, WORD_GAP: begin
          if (done) begin
            tmr_q  <= '0;
            unit_q <= '0;
            case (state_q)
              MARK:    state_q <= (idx_q != '0) ? GAP : CHAR_GAP;
              GAP: begin
                state_q <= MARK;
                idx_q   <= idx_q - IDX_W'(1);
              end
              default: state_q <= IDLE;
            endcase
          end else begin
            tmr_q <= tick ? '0 : tmr_q + TW'(1);
            if (tick) unit_q <= unit_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_o   = key_q;
  assign dot_o   = dot_q;
  assign dash_o  = dash_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != IDLE) || !fifo_empty;
  assign state_o = state_q;

endmodule
